// File: rtl/xbar_ch_req_buf.sv
// xbar_ch_req_buf: per-channel request input buffer in front of the cross bar.
// Accepts one request per cycle over a valid/allowIn handshake, queues it in
// a DEPTH-entry FIFO and presents the head as a line-aligned request with the
// byte offset carried separately.
// Optional feature macro: XBAR_CH_REQ_BUF_BYPASS_EN. When defined, a request
// arriving at an empty buffer is presented in the same cycle. If the arbiter
// takes it, it is never written to the FIFO.
module xbar_ch_req_buf #(
  parameter int CH_ID = 0,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mcash_req_valid_i,
  output logic             mcash_req_allowIn_o,
  input  logic [2:0]       mcash_req_op_i,
  input  logic [31:0]      mcash_req_addr_i,
  input  logic [63:0]      mcash_req_data_i,
  output logic             xbar_req_valid_o,
  input  logic             xbar_req_allowIn_i,
  output logic [1:0]       xbar_req_ch_o,
  output logic [2:0]       xbar_req_op_o,
  output logic [31:0]      xbar_req_addr_o,
  output logic [3:0]       xbar_req_offset_o,
  output logic [63:0]      xbar_req_data_o,
  output logic [PTR_W:0]   buf_cnt_o
);

  // Pointers carry an extra wrap bit so that full and empty can be told apart.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           rdy_q;

  // Payload storage is not reset; the empty flag masks stale contents.
  logic [2:0]  op_mem   [DEPTH];
  logic [31:0] addr_mem [DEPTH];
  logic [63:0] data_mem [DEPTH];

  logic full, empty;
  logic push, pop_fifo, wr_en;
  logic byp_act, byp_take;

  logic [2:0]  head_op;
  logic [31:0] head_addr;
  logic [63:0] head_data;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // Depends only on registered state, which keeps the arbiter's pop off this
  // path. The price is a one-cycle bubble when a pop happens while full.
  assign mcash_req_allowIn_o = rdy_q & ~full;
  assign push                = mcash_req_valid_i & mcash_req_allowIn_o;

`ifdef XBAR_CH_REQ_BUF_BYPASS_EN
  assign byp_act  = empty & push;
  assign byp_take = byp_act & xbar_req_allowIn_i;
`else
  assign byp_act  = 1'b0;
  assign byp_take = 1'b0;
`endif

  assign wr_en            = push & ~byp_take;
  assign pop_fifo         = ~empty & xbar_req_allowIn_i;
  assign xbar_req_valid_o = ~empty | byp_act;

  // Pointer next-state: advance on write and on FIFO pop, with natural wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en)    wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_fifo) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Control state: pointers and ready flag, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_q    <= 1'b1;
    end
  end

  // Payload write at the write pointer. The address is stored unaligned.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      op_mem[wr_ptr_q[PTR_W-1:0]]   <= mcash_req_op_i;
      addr_mem[wr_ptr_q[PTR_W-1:0]] <= mcash_req_addr_i;
      data_mem[wr_ptr_q[PTR_W-1:0]] <= mcash_req_data_i;
    end
  end

  // Head select: bypassed input, FIFO head, or zeros when nothing is valid.
  always_comb begin
    head_op   = '0;
    head_addr = '0;
    head_data = '0;
    if (byp_act) begin
      head_op   = mcash_req_op_i;
      head_addr = mcash_req_addr_i;
      head_data = mcash_req_data_i;
    end else if (!empty) begin
      head_op   = op_mem[rd_ptr_q[PTR_W-1:0]];
      head_addr = addr_mem[rd_ptr_q[PTR_W-1:0]];
      head_data = data_mem[rd_ptr_q[PTR_W-1:0]];
    end
  end

  assign xbar_req_ch_o     = 2'(CH_ID);
  assign xbar_req_op_o     = head_op;
  assign xbar_req_addr_o   = {head_addr[31:4], 4'b0000};
  assign xbar_req_offset_o = head_addr[3:0];
  assign xbar_req_data_o   = head_data;
  assign buf_cnt_o         = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_xbar_ch_req_buf.sv
// Directed testbench for xbar_ch_req_buf (CH_ID=2, DEPTH=4).
module tb_xbar_ch_req_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        allow_o;
  logic [2:0]  op_i;
  logic [31:0] addr_i;
  logic [63:0] data_i;
  logic        xvalid_o;
  logic        xallow_i;
  logic [1:0]  ch_o;
  logic [2:0]  op_o;
  logic [31:0] addr_o;
  logic [3:0]  off_o;
  logic [63:0] data_o;
  logic [2:0]  cnt_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  xbar_ch_req_buf #(.CH_ID(2), .DEPTH(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mcash_req_valid_i   (valid_i),
    .mcash_req_allowIn_o (allow_o),
    .mcash_req_op_i      (op_i),
    .mcash_req_addr_i    (addr_i),
    .mcash_req_data_i    (data_i),
    .xbar_req_valid_o    (xvalid_o),
    .xbar_req_allowIn_i  (xallow_i),
    .xbar_req_ch_o       (ch_o),
    .xbar_req_op_o       (op_o),
    .xbar_req_addr_o     (addr_o),
    .xbar_req_offset_o   (off_o),
    .xbar_req_data_o     (data_o),
    .buf_cnt_o           (cnt_o)
  );

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; xallow_i = 1'b0;
    op_i = '0; addr_i = '0; data_i = '0;
    #1;
    tests_run++; if (allow_o !== 1'b0) begin tests_failed++; $display("FAIL reset_allow got %b exp 0", allow_o); end
    tests_run++; if (xvalid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", xvalid_o); end
    tests_run++; if (cnt_o !== 3'd0) begin tests_failed++; $display("FAIL reset_cnt got %0d exp 0", cnt_o); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    tests_run++; if (allow_o !== 1'b0) begin tests_failed++; $display("FAIL release_cycle_allow got %b exp 0", allow_o); end
    step(); #1;
    tests_run++; if (allow_o !== 1'b1) begin tests_failed++; $display("FAIL post_release_allow got %b exp 1", allow_o); end
    tests_run++; if (xvalid_o !== 1'b0) begin tests_failed++; $display("FAIL post_release_valid got %b exp 0", xvalid_o); end
    tests_run++; if (cnt_o !== 3'd0) begin tests_failed++; $display("FAIL post_release_cnt got %0d exp 0", cnt_o); end
    tests_run++; if (addr_o !== 32'h0 || data_o !== 64'h0) begin tests_failed++; $display("FAIL empty_payload got addr %h data %h exp 0", addr_o, data_o); end
  endtask

  task automatic test_single_push();
    valid_i = 1'b1; op_i = 3'd1; addr_i = 32'h0000_1234; data_i = 64'hDEAD_BEEF_0000_0001;
    xallow_i = 1'b0;
    step();
    valid_i = 1'b0; xallow_i = 1'b1;
    #1;
    tests_run++; if (xvalid_o !== 1'b1) begin tests_failed++; $display("FAIL single_valid got %b exp 1", xvalid_o); end
    tests_run++; if (addr_o !== 32'h0000_1230) begin tests_failed++; $display("FAIL single_addr got %h exp 00001230", addr_o); end
    tests_run++; if (off_o !== 4'h4) begin tests_failed++; $display("FAIL single_offset got %h exp 4", off_o); end
    tests_run++; if (data_o !== 64'hDEAD_BEEF_0000_0001) begin tests_failed++; $display("FAIL single_data got %h exp deadbeef00000001", data_o); end
    tests_run++; if (op_o !== 3'd1) begin tests_failed++; $display("FAIL single_op got %0d exp 1", op_o); end
    tests_run++; if (ch_o !== 2'd2) begin tests_failed++; $display("FAIL single_ch got %0d exp 2", ch_o); end
    tests_run++; if (cnt_o !== 3'd1) begin tests_failed++; $display("FAIL single_cnt got %0d exp 1", cnt_o); end
    step(); #1;
    tests_run++; if (cnt_o !== 3'd0) begin tests_failed++; $display("FAIL single_cnt_after_pop got %0d exp 0", cnt_o); end
    tests_run++; if (xvalid_o !== 1'b0) begin tests_failed++; $display("FAIL single_valid_after_pop got %b exp 0", xvalid_o); end
    xallow_i = 1'b0;
  endtask

  task automatic test_fill_drain();
    xallow_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; op_i = 3'(i); addr_i = 32'(i * 16); data_i = 64'(i + 64'h50);
      step();
    end
    #1;
    tests_run++; if (cnt_o !== 3'd4) begin tests_failed++; $display("FAIL fill_cnt got %0d exp 4", cnt_o); end
    tests_run++; if (allow_o !== 1'b0) begin tests_failed++; $display("FAIL fill_allow got %b exp 0", allow_o); end
    op_i = 3'd7; addr_i = 32'h40; data_i = 64'hFF;
    step(); #1;
    tests_run++; if (cnt_o !== 3'd4) begin tests_failed++; $display("FAIL fifth_rejected_cnt got %0d exp 4", cnt_o); end
    tests_run++; if (addr_o !== 32'h0) begin tests_failed++; $display("FAIL head_stable_addr got %h exp 0", addr_o); end
    valid_i = 1'b0; xallow_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (xvalid_o !== 1'b1 || addr_o !== 32'(i * 16) || op_o !== 3'(i) || data_o !== 64'(i + 64'h50))
        begin tests_failed++; $display("FAIL drain_order_%0d got v%b addr %h op %0d data %h exp addr %h", i, xvalid_o, addr_o, op_o, data_o, 32'(i * 16)); end
      if (i == 0) begin
        tests_run++; if (allow_o !== 1'b0) begin tests_failed++; $display("FAIL allow_during_full_pop got %b exp 0", allow_o); end
      end
      step(); #1;
      if (i == 0) begin
        tests_run++; if (allow_o !== 1'b1) begin tests_failed++; $display("FAIL allow_after_first_pop got %b exp 1", allow_o); end
      end
    end
    tests_run++; if (xvalid_o !== 1'b0 || cnt_o !== 3'd0) begin tests_failed++; $display("FAIL drain_empty got v%b cnt %0d exp v0 cnt 0", xvalid_o, cnt_o); end
    xallow_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_d;
    xallow_i = 1'b1; op_i = 3'd2; addr_i = 32'h100;
    for (int k = 0; k < 20; k++) begin
      valid_i = 1'b1; data_i = 64'(100 + k);
      #1;
      tests_run++; if (allow_o !== 1'b1) begin tests_failed++; $display("FAIL stream_allow_%0d got %b exp 1", k, allow_o); end
`ifdef XBAR_CH_REQ_BUF_BYPASS_EN
      exp_d = 64'(100 + k);
      tests_run++; if (xvalid_o !== 1'b1 || data_o !== exp_d) begin tests_failed++; $display("FAIL stream_%0d got v%b data %0d exp v1 data %0d", k, xvalid_o, data_o, exp_d); end
`else
      if (k == 0) begin
        tests_run++; if (xvalid_o !== 1'b0) begin tests_failed++; $display("FAIL stream_first_latency got v%b exp 0", xvalid_o); end
      end else begin
        exp_d = 64'(100 + k - 1);
        tests_run++; if (xvalid_o !== 1'b1 || data_o !== exp_d) begin tests_failed++; $display("FAIL stream_%0d got v%b data %0d exp v1 data %0d", k, xvalid_o, data_o, exp_d); end
      end
`endif
      step();
    end
    valid_i = 1'b0;
    #1;
`ifndef XBAR_CH_REQ_BUF_BYPASS_EN
    tests_run++; if (xvalid_o !== 1'b1 || data_o !== 64'd119) begin tests_failed++; $display("FAIL stream_last got v%b data %0d exp v1 data 119", xvalid_o, data_o); end
`endif
    step(); #1;
    tests_run++; if (xvalid_o !== 1'b0 || cnt_o !== 3'd0) begin tests_failed++; $display("FAIL stream_end got v%b cnt %0d exp v0 cnt 0", xvalid_o, cnt_o); end
    xallow_i = 1'b0;
  endtask

  task automatic test_async_reset();
    xallow_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; op_i = 3'd5; addr_i = 32'hA0 + 32'(i); data_i = 64'hAA00 + 64'(i);
      step();
    end
    valid_i = 1'b0;
    #1;
    tests_run++; if (cnt_o !== 3'd3) begin tests_failed++; $display("FAIL pre_reset_cnt got %0d exp 3", cnt_o); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (xvalid_o !== 1'b0) begin tests_failed++; $display("FAIL async_reset_valid got %b exp 0", xvalid_o); end
    tests_run++; if (cnt_o !== 3'd0) begin tests_failed++; $display("FAIL async_reset_cnt got %0d exp 0", cnt_o); end
    tests_run++; if (allow_o !== 1'b0) begin tests_failed++; $display("FAIL async_reset_allow got %b exp 0", allow_o); end
    #1 rst_n = 1'b1;
    step();
    xallow_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++; if (xvalid_o !== 1'b0 || addr_o !== 32'h0 || data_o !== 64'h0)
        begin tests_failed++; $display("FAIL stale_entry_%0d got v%b addr %h data %h exp all 0", i, xvalid_o, addr_o, data_o); end
      step();
    end
    xallow_i = 1'b0;
  endtask

  task automatic test_bypass();
    xallow_i = 1'b1; valid_i = 1'b1; op_i = 3'd6; addr_i = 32'h0000_BEE7; data_i = 64'h1234_5678_9ABC_DEF0;
    #1;
`ifdef XBAR_CH_REQ_BUF_BYPASS_EN
    tests_run++; if (xvalid_o !== 1'b1 || data_o !== 64'h1234_5678_9ABC_DEF0 || addr_o !== 32'h0000_BEE0 || off_o !== 4'h7)
      begin tests_failed++; $display("FAIL bypass_same_cycle got v%b addr %h off %h data %h", xvalid_o, addr_o, off_o, data_o); end
`else
    tests_run++; if (xvalid_o !== 1'b0) begin tests_failed++; $display("FAIL no_bypass_same_cycle got v%b exp 0", xvalid_o); end
`endif
    step();
    valid_i = 1'b0;
    #1;
`ifdef XBAR_CH_REQ_BUF_BYPASS_EN
    tests_run++; if (xvalid_o !== 1'b0 || cnt_o !== 3'd0) begin tests_failed++; $display("FAIL bypass_no_write got v%b cnt %0d exp v0 cnt 0", xvalid_o, cnt_o); end
`else
    tests_run++; if (xvalid_o !== 1'b1 || data_o !== 64'h1234_5678_9ABC_DEF0 || cnt_o !== 3'd1)
      begin tests_failed++; $display("FAIL no_bypass_next_cycle got v%b data %h cnt %0d", xvalid_o, data_o, cnt_o); end
`endif
    step(); #1;
    tests_run++; if (xvalid_o !== 1'b0 || cnt_o !== 3'd0) begin tests_failed++; $display("FAIL bypass_end got v%b cnt %0d exp v0 cnt 0", xvalid_o, cnt_o); end
    xallow_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_async_reset();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
